// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer helpers for the dual-clock gray-pointer FIFO
package fifo_pkg;

  localparam int ADDRSIZE_DEF = 4;
  localparam int PTRW_DEF     = ADDRSIZE_DEF + 1;

  // Wide enough for any pointer; callers cast the result down to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/sync_w2r.sv
// rtl/sync_w2r.sv - multi-flop synchronizer carrying the write gray pointer into rclk
module sync_w2r
  import fifo_pkg::*;
#(
  parameter int WIDTH       = PTRW_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rptr_empty_fwft.sv
// rtl/rptr_empty_fwft.sv - FIFO read-side controller: gray rptr, empty flag, 2-entry FWFT output
module rptr_empty_fwft
  import fifo_pkg::*;
#(
  parameter int DSIZE       = 8,
  parameter int ADDRSIZE    = ADDRSIZE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                ren,
  input  logic [DSIZE-1:0]    mem_rdata,
  output logic                rempty,
  output logic                m_tvalid,
  output logic [DSIZE-1:0]    m_tdata,
  input  logic                m_tready
);

  localparam int PTRW = ADDRSIZE + 1;

  logic [PTRW-1:0]  rq_wptr;
  logic [PTRW-1:0]  rbin_q, rbin_d;
  logic [PTRW-1:0]  rptr_q, rptr_d;
  logic             rempty_q, rempty_d;
  logic             rd_pend_q;
  logic [DSIZE-1:0] buf_q [2];
  logic             wr_idx_q, rd_idx_q;
  logic [1:0]       count_q, count_d;
  logic             push, pop;
  logic [2:0]       occ, occ_after_pop;

  sync_w2r #(
    .WIDTH      (PTRW),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_w2r (
    .clk_i (rclk),
    .rst_ni(rrst_n),
    .d_i   (wptr),
    .q_o   (rq_wptr)
  );

  // Credit counts words held plus the read still in flight, so the buffer can never overflow.
  always_comb begin
    push          = rd_pend_q;
    pop           = m_tvalid & m_tready;
    occ           = {1'b0, count_q} + {2'b00, rd_pend_q};
    occ_after_pop = occ - {2'b00, pop};
    ren           = ~rempty_q & (occ_after_pop < 3'd2);
    rbin_d        = rbin_q + {{ADDRSIZE{1'b0}}, ren};
    rptr_d        = PTRW'(bin2gray(32'(rbin_d)));
    rempty_d      = (rptr_d == rq_wptr);
    count_d       = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rempty_q  <= 1'b1;
      rd_pend_q <= 1'b0;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
      wr_idx_q  <= 1'b0;
      rd_idx_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      rempty_q  <= rempty_d;
      rd_pend_q <= ren;
      count_q   <= count_d;
      if (push) begin
        buf_q[wr_idx_q] <= mem_rdata;
        wr_idx_q        <= ~wr_idx_q;
      end
      if (pop) rd_idx_q <= ~rd_idx_q;
    end
  end

  assign rptr     = rptr_q;
  assign raddr    = rbin_q[ADDRSIZE-1:0];
  assign rempty   = rempty_q;
  assign m_tvalid = (count_q != 2'd0);
  assign m_tdata  = buf_q[rd_idx_q];

  a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst_n) push |-> (count_q != 2'd2));

endmodule
